// File: rtl/i2s_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : i2s_rx_fifo
// Brief   : I2S receiver (master/slave, I2S or left-justified, 16/32-bit) with
//           an 8-deep word FIFO. Macro RX_SIGN_EXT_EN sign-extends 16-bit words.
// Rev     : 1.0
// ============================================================================
module i2s_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [1:0]  standard,
  input  logic        stereo,
  input  logic        frame_size,
  input  logic        sd,
  inout  wire         ws,
  input  logic        ren,
  output logic [31:0] dout,
  output logic        dout_ch,
  output logic        dout_valid,
  output logic        full,
  output logic        empty,
  output logic        ovf
);

  // mode encoding: 00 = MT, 01 = MR, 10 = ST, 11 = SR
  localparam logic [1:0] MODE_MR = 2'b01;
  localparam logic [1:0] MODE_SR = 2'b11;
  localparam logic [1:0] STD_I2S = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WAIT1 = 2'b01,
    S_SHIFT = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic          ws_gen_q, ws_gen_d;
  logic [4:0]    ws_cnt_q, ws_cnt_d;
  logic          ws_d_q, ws_d_d;
  logic [31:0]   shreg_q, shreg_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic          ch_q, ch_d;
  logic          pend_q, pend_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [31:0]   dout_q, dout_d;
  logic          dout_ch_q, dout_ch_d;
  logic          dout_valid_q, dout_valid_d;
  logic          ovf_q, ovf_d;
  logic [32:0]   mem_q [DEPTH];

  logic          is_mr;
  logic          is_rx;
  logic          is_lj;
  logic          ws_i;
  logic          ws_edge;
  logic [4:0]    last_cnt;
  logic          push_req;
  logic          restart;
  logic          start_msb;
  logic          push_en;
  logic          push_ok;
  logic          pop_ok;
  logic [31:0]   word;
  logic [32:0]   rd_entry;

  assign is_mr    = (mode == MODE_MR);
  assign is_rx    = is_mr || (mode == MODE_SR);
  assign is_lj    = (standard != STD_I2S);
  assign last_cnt = frame_size ? 5'd31 : 5'd15;

  // In master mode the internal copy avoids depending on pad read-back.
  assign ws      = is_mr ? ws_gen_q : 1'bz;
  assign ws_i    = is_mr ? ws_gen_q : ws;
  assign ws_edge = is_rx && (ws_i != ws_d_q);

  always_comb begin
    ws_cnt_d = 5'd0;
    ws_gen_d = 1'b1;
    ws_d_d   = ws_i;
    if (is_mr) begin
      if (ws_cnt_q == last_cnt) begin
        ws_cnt_d = 5'd0;
        ws_gen_d = ~ws_gen_q;
      end else begin
        ws_cnt_d = ws_cnt_q + 5'd1;
        ws_gen_d = ws_gen_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    ch_d      = ch_q;
    pend_d    = 1'b0;
    push_req  = 1'b0;
    restart   = 1'b0;
    start_msb = 1'b0;

    case (state_q)
      S_IDLE: begin
        restart = ws_edge;
      end
      S_WAIT1: begin
        if (ws_edge) begin
          restart = 1'b1;
        end else begin
          start_msb = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bitcnt_q == 5'd0) begin
          push_req = 1'b1;
          state_d  = S_IDLE;
          if (ws_edge) begin
            restart = 1'b1;
          end else if (pend_q) begin
            start_msb = 1'b1;
          end
        // An I2S edge lands on the LSB clk of the current word, so it is not an abort.
        end else if (ws_edge && !((bitcnt_q == 5'd1) && !is_lj)) begin
          restart = 1'b1;
        end else begin
          shreg_d  = {shreg_q[30:0], sd};
          bitcnt_d = bitcnt_q - 5'd1;
          pend_d   = ws_edge;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (restart) begin
      if (is_lj) begin
        start_msb = 1'b1;
      end else begin
        state_d = S_WAIT1;
      end
    end

    if (start_msb) begin
      shreg_d  = {shreg_q[30:0], sd};
      bitcnt_d = last_cnt;
      ch_d     = ws_i;
      state_d  = S_SHIFT;
    end

    if (!is_rx) begin
      state_d  = S_IDLE;
      pend_d   = 1'b0;
      push_req = 1'b0;
    end
  end

  always_comb begin
    word = shreg_q;
    if (!frame_size) begin
`ifdef RX_SIGN_EXT_EN
      word = {{16{shreg_q[15]}}, shreg_q[15:0]};
`else
      word = {16'h0000, shreg_q[15:0]};
`endif
    end
  end

  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty    = (wptr_q == rptr_q);
  assign pop_ok   = ren && !empty;
  // Mono capture silently drops right-channel words.
  assign push_en  = push_req && (stereo || !ch_q);
  assign push_ok  = push_en && (!full || pop_ok);
  assign rd_entry = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d       = wptr_q + {{AW{1'b0}}, push_ok};
    rptr_d       = rptr_q + {{AW{1'b0}}, pop_ok};
    ovf_d        = ovf_q | (push_en && full && !pop_ok);
    dout_valid_d = pop_ok;
    dout_d       = dout_q;
    dout_ch_d    = dout_ch_q;
    if (pop_ok) begin
      dout_d    = rd_entry[31:0];
      dout_ch_d = rd_entry[32];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= {ch_q, word};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ws_gen_q     <= 1'b1;
      ws_cnt_q     <= 5'd0;
      ws_d_q       <= 1'b1;
      shreg_q      <= 32'd0;
      bitcnt_q     <= 5'd0;
      ch_q         <= 1'b0;
      pend_q       <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      dout_q       <= 32'd0;
      dout_ch_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ws_gen_q     <= ws_gen_d;
      ws_cnt_q     <= ws_cnt_d;
      ws_d_q       <= ws_d_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      ch_q         <= ch_d;
      pend_q       <= pend_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = dout_valid_q;
  assign ovf        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2s_rx_fifo
// Brief   : Scoreboard bench for i2s_rx_fifo; honours RX_SIGN_EXT_EN.
// Rev     : 1.0
// ============================================================================
module tb_i2s_rx_fifo;

  localparam logic [1:0] MODE_MT = 2'b00;
  localparam logic [1:0] MODE_MR = 2'b01;
  localparam logic [1:0] MODE_SR = 2'b11;
  localparam logic [1:0] STD_I2S = 2'b00;
  localparam logic [1:0] STD_LJ  = 2'b01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = MODE_SR;
  logic [1:0]  standard = STD_I2S;
  logic        stereo = 1'b1;
  logic        frame_size = 1'b0;
  logic        sd = 1'b0;
  logic        ren = 1'b0;
  logic        tb_ws = 1'b1;
  logic        tb_ws_en = 1'b1;
  wire         ws;
  logic [31:0] dout;
  logic        dout_ch;
  logic        dout_valid;
  logic        full;
  logic        empty;
  logic        ovf;

  int          total = 0;
  int          bad = 0;
  logic [32:0] sb[$];
  bit          ws_q[$];
  bit          sd_q[$];

  assign ws = tb_ws_en ? tb_ws : 1'bz;

  always #5 clk = ~clk;

  i2s_rx_fifo #(.DEPTH(8), .AW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .standard   (standard),
    .stereo     (stereo),
    .frame_size (frame_size),
    .sd         (sd),
    .ws         (ws),
    .ren        (ren),
    .dout       (dout),
    .dout_ch    (dout_ch),
    .dout_valid (dout_valid),
    .full       (full),
    .empty      (empty),
    .ovf        (ovf)
  );

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext16(input logic [15:0] w);
`ifdef RX_SIGN_EXT_EN
    return {{16{w[15]}}, w};
`else
    return {16'h0000, w};
`endif
  endfunction

  // Popped words are matched against the scoreboard in order.
  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      if (sb.size() == 0) check("pop_without_expected", 33'(sb.size()), 33'd1);
      else                check("pop_word", {dout_ch, dout}, sb.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add_word(input bit w, input logic [31:0] d, input int n, input bit keep);
    for (int i = n - 1; i >= 0; i--) begin
      ws_q.push_back(w);
      sd_q.push_back(d[i]);
    end
    if (keep) sb.push_back({w, (n == 16) ? ext16(d[15:0]) : d});
  endtask

  task automatic add_raw(input bit w, input int n);
    for (int i = 0; i < n; i++) begin
      ws_q.push_back(w);
      sd_q.push_back(i[0]);
    end
  endtask

  // Slot j drives ws/sd for the posedge following that negedge; I2S delays sd one slot.
  task automatic play(input bit i2s, input bit chk_ws);
    int len;
    int k;
    len = ws_q.size();
    for (int j = 0; j < len + 3; j++) begin
      @(negedge clk);
      if (chk_ws && j < len) check("mr_ws", 33'(ws), 33'(ws_q[j]));
      tb_ws = ws_q[(j < len) ? j : len - 1];
      k = i2s ? j - 1 : j;
      sd = (k >= 0 && k < len) ? sd_q[k] : 1'b0;
    end
    ws_q.delete();
    sd_q.delete();
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [1:0] s, input bit st, input bit fs);
    @(negedge clk);
    rst = 1'b1; ren = 1'b0; sd = 1'b0; tb_ws = 1'b1;
    mode = m; standard = s; stereo = st; frame_size = fs;
    tb_ws_en = (m != MODE_MR);
    sb.delete();
    tick(3);
    rst = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ren = 1'b1;
    end
    @(negedge clk);
    ren = 1'b0;
    tick(1);
  endtask

  initial begin
    // Reset state
    do_reset(MODE_SR, STD_I2S, 1'b1, 1'b0);
    tick(1);
    check("rst_dout", 33'(dout), 33'd0);
    check("rst_dout_ch", 33'(dout_ch), 33'd0);
    check("rst_dout_valid", 33'(dout_valid), 33'd0);
    check("rst_empty", 33'(empty), 33'd1);
    check("rst_full", 33'(full), 33'd0);
    check("rst_ovf", 33'(ovf), 33'd0);

    // Slave, I2S, 16-bit stereo
    add_word(1'b0, 32'h0000A5C3, 16, 1'b1);
    add_word(1'b1, 32'h00001234, 16, 1'b1);
    play(1'b1, 1'b0);
    tick(2);
    pop_n(2);
    check("i2s16_empty", 33'(empty), 33'd1);
    check("i2s16_sb_left", 33'(sb.size()), 33'd0);

    // Slave, left-justified, 32-bit
    do_reset(MODE_SR, STD_LJ, 1'b1, 1'b1);
    add_word(1'b0, 32'hDEADBEEF, 32, 1'b1);
    add_word(1'b1, 32'h0F1E2D3C, 32, 1'b1);
    play(1'b0, 1'b0);
    tick(2);
    pop_n(2);
    check("lj32_sb_left", 33'(sb.size()), 33'd0);

    // Master, left-justified, 16-bit: ws falls N clks after release
    do_reset(MODE_MR, STD_LJ, 1'b1, 1'b0);
    for (int p = 1; p <= 15; p++) begin
      @(negedge clk);
      if (p == 1 || p == 15) check("mr_ws_initial", 33'(ws), 33'd1);
    end
    add_word(1'b0, 32'h00005A0F, 16, 1'b1);
    add_word(1'b1, 32'h0000C3C3, 16, 1'b1);
    play(1'b0, 1'b1);
    tick(2);
    pop_n(2);
    check("mr_sb_left", 33'(sb.size()), 33'd0);

    // Overflow: 8 words fill, 9th dropped
    do_reset(MODE_SR, STD_I2S, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) add_word(bit'((i - 1) % 2), 32'(i), 16, 1'b1);
    play(1'b1, 1'b0);
    tick(2);
    check("ovf_full_after8", 33'(full), 33'd1);
    check("ovf_clear_after8", 33'(ovf), 33'd0);
    add_word(1'b0, 32'd9, 16, 1'b0);
    play(1'b1, 1'b0);
    tick(2);
    check("ovf_set_after9", 33'(ovf), 33'd1);
    check("ovf_full_after9", 33'(full), 33'd1);
    pop_n(8);
    check("ovf_empty_after_pops", 33'(empty), 33'd1);
    check("ovf_sb_left", 33'(sb.size()), 33'd0);

    // Abort: ws toggles after 8 bits of each word
    add_raw(1'b1, 9);
    add_raw(1'b0, 9);
    add_raw(1'b1, 9);
    add_raw(1'b0, 9);
    play(1'b1, 1'b0);
    check("abort_empty", 33'(empty), 33'd1);
    check("ovf_sticky", 33'(ovf), 33'd1);

    // Reset mid-word on a non-empty FIFO, with a pop requested
    add_word(1'b1, 32'h00001111, 16, 1'b0);
    add_word(1'b0, 32'h00002222, 16, 1'b0);
    add_raw(1'b1, 6);
    play(1'b1, 1'b0);
    check("prefill_not_empty", 33'(empty), 33'd0);
    @(negedge clk);
    rst = 1'b1;
    ren = 1'b1;
    @(negedge clk);
    check("midrst_empty", 33'(empty), 33'd1);
    check("midrst_full", 33'(full), 33'd0);
    check("midrst_ovf", 33'(ovf), 33'd0);
    check("midrst_dout_valid", 33'(dout_valid), 33'd0);
    check("midrst_dout", 33'(dout), 33'd0);
    rst = 1'b0;
    ren = 1'b0;
    tick(40);
    check("post_rst_empty", 33'(empty), 33'd1);

    // Mono: right-channel words discarded without overflow
    do_reset(MODE_SR, STD_I2S, 1'b0, 1'b0);
    add_word(1'b0, 32'h00000001, 16, 1'b1);
    add_word(1'b1, 32'h00000002, 16, 1'b0);
    add_word(1'b0, 32'h00000001, 16, 1'b1);
    add_word(1'b1, 32'h00000002, 16, 1'b0);
    play(1'b1, 1'b0);
    tick(2);
    pop_n(2);
    check("mono_empty", 33'(empty), 33'd1);
    check("mono_ovf", 33'(ovf), 33'd0);
    check("mono_sb_left", 33'(sb.size()), 33'd0);

    // Pop while empty: ignored, dout holds
    @(negedge clk);
    ren = 1'b1;
    @(negedge clk);
    ren = 1'b0;
    check("empty_pop_valid", 33'(dout_valid), 33'd0);
    check("empty_pop_dout_hold", 33'(dout), 33'h000000001);

    // 16-bit word with MSB set (sign extension when enabled)
    do_reset(MODE_SR, STD_LJ, 1'b1, 1'b0);
    add_word(1'b0, 32'h00008001, 16, 1'b1);
    play(1'b0, 1'b0);
    tick(2);
    pop_n(1);
    check("sign_sb_left", 33'(sb.size()), 33'd0);

    // Transmit mode: receiver idle
    @(negedge clk);
    mode = MODE_MT;
    add_word(1'b0, 32'h0000BEEF, 16, 1'b0);
    add_word(1'b1, 32'h0000CAFE, 16, 1'b0);
    play(1'b0, 1'b0);
    tick(20);
    check("mt_no_capture", 33'(empty), 33'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
